// File: rtl/conv_enc_pkg.sv
// Shared constants, state type and coding helper for the
// LTE rate-1/3 tail-biting convolutional encoder (K=7).
package conv_enc_pkg;

   localparam logic [6:0] G0 = 7'b1011011;
   localparam logic [6:0] G1 = 7'b1111001;
   localparam logic [6:0] G2 = 7'b1110101;

   localparam int K_SMALL_DEF = 1056;
   localparam int K_LARGE_DEF = 6144;

   typedef enum logic [2:0] {
      IDLE,
      LOAD_META,
      LOAD_TAIL,
      ENCODE,
      DONE
   } enc_state_t;

   function automatic logic [2:0] code_bits(
      input logic [6:0] c
   );
      return {^(c & G2), ^(c & G1), ^(c & G0)};
   endfunction

endpackage

// File: rtl/conv_enc_if.sv
// Write-side and encoder-output signal bundle of the encoder.
// master drives the FIFO writes and blk_ready; slave is the encoder.
interface conv_enc_if;

   logic        blk_ready;
   logic [7:0]  fifo_w_data;
   logic        wrreq_data;
   logic [7:0]  fifo_w_meta;
   logic        wrreq_meta;

   logic [7:0]  blk_data;
   logic [7:0]  blk_meta;
   logic [6:0]  cOut;
   logic [2:0]  dOut;
   logic        computation_done;
   logic        instantiate_computation;
   logic        compute_enable;
   logic [12:0] counter_out;
   logic [2:0]  counter_mod;
   logic [7:0]  out_to_fifo0;
   logic [7:0]  out_to_fifo1;
   logic [7:0]  out_to_fifo2;

   modport master (
      output blk_ready, fifo_w_data, wrreq_data,
      output fifo_w_meta, wrreq_meta,
      input  blk_data, blk_meta, cOut, dOut,
      input  computation_done, instantiate_computation,
      input  compute_enable, counter_out, counter_mod,
      input  out_to_fifo0, out_to_fifo1, out_to_fifo2
   );

   modport slave (
      input  blk_ready, fifo_w_data, wrreq_data,
      input  fifo_w_meta, wrreq_meta,
      output blk_data, blk_meta, cOut, dOut,
      output computation_done, instantiate_computation,
      output compute_enable, counter_out, counter_mod,
      output out_to_fifo0, out_to_fifo1, out_to_fifo2
   );

endinterface

// File: rtl/conv_enc_core.sv
// K=7 encoder shift register: tail load, shift, window and coded bits.
// st[5] holds s0 (most recent bit), st[0] holds s5.
module conv_enc_core
   import conv_enc_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic [5:0] tail,
   input  logic       shift,
   input  logic       u,
   output logic [6:0] c_out,
   output logic [2:0] d_out
);

   logic [5:0] st;

   // tail[0] is the last block bit, so it becomes s0
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         st <= '0;
      end else if (load) begin
         st <= {tail[0], tail[1], tail[2],
                tail[3], tail[4], tail[5]};
      end else if (shift) begin
         st <= {u, st[5:1]};
      end
   end

   assign c_out = {u, st};
   assign d_out = code_bits(c_out);

endmodule

// File: rtl/conv_enc_skeleton.sv
// Encoder top: data/meta buffering, block FSM, bit counter,
// output byte packing around the conv_enc_core shift register.
module conv_enc_skeleton
   import conv_enc_pkg::*;
#(
   parameter int K_SMALL    = K_SMALL_DEF,
   parameter int K_LARGE    = K_LARGE_DEF,
   parameter int DATA_DEPTH = 2048,
   parameter int META_DEPTH = 4
) (
   input  logic       clk,
   input  logic       reset,
   conv_enc_if.slave  bus
);

   localparam int AW  = $clog2(DATA_DEPTH);
   localparam int CW  = AW + 1;
   localparam int MW  = $clog2(META_DEPTH);
   localparam int MCW = MW + 1;

   localparam logic [CW-1:0] KB_S = CW'(K_SMALL / 8);
   localparam logic [CW-1:0] KB_L = CW'(K_LARGE / 8);
   localparam logic [12:0]   KL_S = 13'(K_SMALL - 1);
   localparam logic [12:0]   KL_L = 13'(K_LARGE - 1);

   enc_state_t state, nxt;

   logic [7:0]     mem      [DATA_DEPTH];
   logic [7:0]     meta_mem [META_DEPTH];
   logic [AW-1:0]  wr_ptr, rd_ptr;
   logic [CW-1:0]  data_cnt;
   logic [MW-1:0]  meta_wr, meta_rd;
   logic [MCW-1:0] meta_cnt;

   logic           k_large;
   logic [12:0]    cnt;
   logic [7:0]     blk_data, blk_meta;
   logic [7:0]     sr0, sr1, sr2;
   logic [7:0]     of0, of1, of2;

   logic           data_wr, meta_push;
   logic [CW-1:0]  head_kb, cur_kb;
   logic [12:0]    k_last;
   logic           start, last_bit, byte_end, adv;
   logic           pop_meta, load_tail, encoding, done;
   logic [AW-1:0]  tail_addr, next_addr;
   logic           u;
   logic [6:0]     c_out;
   logic [2:0]     d_out;

   assign data_wr   = bus.wrreq_data &&
                      (data_cnt != CW'(DATA_DEPTH));
   assign meta_push = bus.wrreq_meta &&
                      (meta_cnt != MCW'(META_DEPTH));

   assign head_kb = meta_mem[meta_rd][0] ? KB_L : KB_S;
   assign cur_kb  = k_large ? KB_L : KB_S;
   assign k_last  = k_large ? KL_L : KL_S;

   assign start = bus.blk_ready &&
                  (meta_cnt != '0) &&
                  (data_cnt >= head_kb);

   // last byte of the block seeds the tail-biting state
   assign tail_addr = rd_ptr + cur_kb[AW-1:0] - AW'(1);
   assign next_addr = rd_ptr + AW'(cnt[12:3]) + AW'(1);

   assign last_bit = cnt == k_last;
   assign byte_end = cnt[2:0] == 3'd7;
   assign adv      = encoding && last_bit;
   assign u        = blk_data[3'd7 - cnt[2:0]];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= nxt;
   end

   always_comb begin
      nxt       = state;
      pop_meta  = 1'b0;
      load_tail = 1'b0;
      encoding  = 1'b0;
      done      = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) nxt = LOAD_META;
         end
         LOAD_META: begin
            pop_meta = 1'b1;
            nxt      = LOAD_TAIL;
         end
         LOAD_TAIL: begin
            load_tail = 1'b1;
            nxt       = ENCODE;
         end
         ENCODE: begin
            encoding = 1'b1;
            if (last_bit) nxt = DONE;
         end
         DONE: begin
            done = 1'b1;
            nxt  = IDLE;
         end
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (data_wr)   mem[wr_ptr]       <= bus.fifo_w_data;
      if (meta_push) meta_mem[meta_wr] <= bus.fifo_w_meta;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         data_cnt <= '0;
         meta_wr  <= '0;
         meta_rd  <= '0;
         meta_cnt <= '0;
      end else begin
         if (data_wr)   wr_ptr  <= wr_ptr + AW'(1);
         if (adv)       rd_ptr  <= rd_ptr + cur_kb[AW-1:0];
         if (meta_push) meta_wr <= meta_wr + MW'(1);
         if (pop_meta)  meta_rd <= meta_rd + MW'(1);
         data_cnt <= data_cnt + CW'(data_wr) -
                     (adv ? cur_kb : '0);
         meta_cnt <= meta_cnt + MCW'(meta_push) -
                     MCW'(pop_meta);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         k_large  <= 1'b0;
         blk_meta <= '0;
         blk_data <= '0;
         cnt      <= '0;
         sr0      <= '0;
         sr1      <= '0;
         sr2      <= '0;
         of0      <= '0;
         of1      <= '0;
         of2      <= '0;
      end else begin
         if (pop_meta) begin
            blk_meta <= meta_mem[meta_rd];
            k_large  <= meta_mem[meta_rd][0];
         end
         if (load_tail) blk_data <= mem[rd_ptr];
         if (encoding) begin
            cnt <= last_bit ? '0 : cnt + 13'd1;
            sr0 <= {sr0[6:0], d_out[0]};
            sr1 <= {sr1[6:0], d_out[1]};
            sr2 <= {sr2[6:0], d_out[2]};
            if (byte_end) begin
               blk_data <= mem[next_addr];
               of0      <= {sr0[6:0], d_out[0]};
               of1      <= {sr1[6:0], d_out[1]};
               of2      <= {sr2[6:0], d_out[2]};
            end
         end
      end
   end

   conv_enc_core u_core (
      .clk   (clk),
      .reset (reset),
      .load  (load_tail),
      .tail  (mem[tail_addr][5:0]),
      .shift (encoding),
      .u     (u),
      .c_out (c_out),
      .d_out (d_out)
   );

   assign bus.blk_data                = blk_data;
   assign bus.blk_meta                = blk_meta;
   assign bus.cOut                    = c_out;
   assign bus.dOut                    = d_out;
   assign bus.computation_done        = done;
   assign bus.instantiate_computation = pop_meta;
   assign bus.compute_enable          = encoding;
   assign bus.counter_out             = cnt;
   assign bus.counter_mod             = cnt[2:0];
   assign bus.out_to_fifo0            = of0;
   assign bus.out_to_fifo1            = of1;
   assign bus.out_to_fifo2            = of2;

endmodule

// File: tb/tb_conv_enc_skeleton.sv
// Bench for conv_enc_skeleton: directed and random blocks checked
// against a modular-index tail-biting reference model.
module tb_conv_enc_skeleton;

   localparam int KS = 32;
   localparam int KL = 128;
   localparam int DD = 16;
   localparam int MD = 4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   conv_enc_if bus ();

   conv_enc_skeleton #(
      .K_SMALL    (KS),
      .K_LARGE    (KL),
      .DATA_DEPTH (DD),
      .META_DEPTH (MD)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   logic [7:0] q_data [$];
   logic [7:0] q_meta [$];
   logic [7:0] pend   [$];

   logic       bits [KL];
   logic [2:0] dx   [KL];
   logic [6:0] first_c;
   logic [2:0] first_d;
   logic [5:0] fin_s;

   // window bit 6-j is the input j steps back, wrapping round the block
   function automatic logic [6:0] window(input int k, input int i);
      logic [6:0] w;
      for (int j = 0; j < 7; j++) w[6-j] = bits[(i - j + k) % k];
      return w;
   endfunction

   function automatic logic [7:0] exp_byte(input int s, input int b);
      logic [7:0] r;
      for (int n = 0; n < 8; n++) r[7-n] = dx[8*b+n][s];
      return r;
   endfunction

   task automatic do_reset();
      bus.blk_ready  = 1'b0;
      bus.wrreq_data = 1'b0;
      bus.wrreq_meta = 1'b0;
      reset = 1'b0;
      q_data.delete();
      q_meta.delete();
      pend.delete();
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic wr_data(input logic [7:0] b);
      bus.fifo_w_data = b;
      bus.wrreq_data  = 1'b1;
      if (q_data.size() < DD) q_data.push_back(b);
      @(negedge clk);
      bus.wrreq_data = 1'b0;
   endtask

   task automatic wr_meta(input logic [7:0] m);
      bus.fifo_w_meta = m;
      bus.wrreq_meta  = 1'b1;
      if (q_meta.size() < MD) q_meta.push_back(m);
      @(negedge clk);
      bus.wrreq_meta = 1'b0;
   endtask

   task automatic run_block(input int abort_at);
      logic [7:0] m;
      logic [7:0] blk [$];
      logic [6:0] w;
      logic [5:0] fs;
      int k, nb;
      bit seen;
      m  = q_meta[0];
      k  = m[0] ? KL : KS;
      nb = k / 8;
      blk.delete();
      for (int b = 0; b < nb; b++) blk.push_back(q_data[b]);
      for (int i = 0; i < k; i++) bits[i] = blk[i/8][7-(i%8)];
      for (int i = 0; i < k; i++) begin
         w = window(k, i);
         dx[i] = {^(w & 7'o165), ^(w & 7'o171), ^(w & 7'o133)};
      end
      for (int j = 0; j < 6; j++) fs[5-j] = bits[k-1-j];
      bus.blk_ready = 1'b1;
      seen = 1'b0;
      for (int t = 0; t < 20 && !seen; t++) begin
         @(negedge clk);
         seen = bus.instantiate_computation;
      end
      bus.blk_ready = 1'b0;
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL start: instantiate_computation got 0 want 1");
         return;
      end
      void'(q_meta.pop_front());
      @(negedge clk);
      checks++;
      if (bus.blk_meta !== m) begin
         errors++;
         $display("FAIL blk_meta got %h want %h", bus.blk_meta, m);
      end
      checks++;
      if (bus.instantiate_computation !== 1'b0) begin
         errors++;
         $display("FAIL inst_pulse got 1 want 0");
      end
      for (int i = 0; i <= k; i++) begin
         @(negedge clk);
         if (i == abort_at) begin
            bus.wrreq_data = 1'b0;
            reset = 1'b0;
            #1;
            checks++;
            if (bus.compute_enable !== 1'b0 || bus.cOut !== 7'h0 ||
                bus.dOut !== 3'h0 || bus.counter_out !== 13'h0 ||
                bus.out_to_fifo0 !== 8'h0 || bus.out_to_fifo1 !== 8'h0 ||
                bus.out_to_fifo2 !== 8'h0 || bus.blk_meta !== 8'h0 ||
                bus.blk_data !== 8'h0) begin
               errors++;
               $display("FAIL abort: en=%b c=%h d=%h cnt=%0d o0=%h bm=%h bd=%h want all 0",
                        bus.compute_enable, bus.cOut, bus.dOut,
                        bus.counter_out, bus.out_to_fifo0,
                        bus.blk_meta, bus.blk_data);
            end
            q_data.delete();
            q_meta.delete();
            pend.delete();
            @(negedge clk);
            reset = 1'b1;
            @(negedge clk);
            return;
         end
         if (i < k && pend.size() > 0) begin
            logic [7:0] b;
            b = pend.pop_front();
            bus.fifo_w_data = b;
            bus.wrreq_data  = 1'b1;
            if (q_data.size() < DD) q_data.push_back(b);
         end else begin
            bus.wrreq_data = 1'b0;
         end
         if (i > 0 && i % 8 == 0) begin
            for (int s = 0; s < 3; s++) begin
               logic [7:0] got;
               got = (s == 0) ? bus.out_to_fifo0 :
                     (s == 1) ? bus.out_to_fifo1 : bus.out_to_fifo2;
               checks++;
               if (got !== exp_byte(s, i/8 - 1)) begin
                  errors++;
                  $display("FAIL out_to_fifo%0d byte %0d got %h want %h",
                           s, i/8 - 1, got, exp_byte(s, i/8 - 1));
               end
            end
         end
         if (i < k) begin
            w = window(k, i);
            if (i == 0) begin
               first_c = bus.cOut;
               first_d = bus.dOut;
            end
            checks++;
            if (bus.cOut !== w) begin
               errors++;
               $display("FAIL cOut bit %0d got %h want %h", i, bus.cOut, w);
            end
            checks++;
            if (bus.dOut !== dx[i]) begin
               errors++;
               $display("FAIL dOut bit %0d got %b want %b", i, bus.dOut, dx[i]);
            end
            checks++;
            if (bus.counter_out !== 13'(i) || bus.counter_mod !== 3'(i % 8)) begin
               errors++;
               $display("FAIL counter bit %0d got %0d/%0d want %0d/%0d",
                        i, bus.counter_out, bus.counter_mod, i, i % 8);
            end
            checks++;
            if (bus.compute_enable !== 1'b1 || bus.computation_done !== 1'b0) begin
               errors++;
               $display("FAIL enable bit %0d got en=%b done=%b want 1/0",
                        i, bus.compute_enable, bus.computation_done);
            end
            checks++;
            if (bus.blk_data !== blk[i/8]) begin
               errors++;
               $display("FAIL blk_data bit %0d got %h want %h",
                        i, bus.blk_data, blk[i/8]);
            end
         end else begin
            fin_s = bus.cOut[5:0];
            checks++;
            if (bus.computation_done !== 1'b1 || bus.compute_enable !== 1'b0 ||
                bus.counter_out !== 13'h0 || bus.counter_mod !== 3'h0) begin
               errors++;
               $display("FAIL done got done=%b en=%b cnt=%0d mod=%0d want 1/0/0/0",
                        bus.computation_done, bus.compute_enable,
                        bus.counter_out, bus.counter_mod);
            end
            checks++;
            if (fin_s !== fs) begin
               errors++;
               $display("FAIL final_state got %b want %b", fin_s, fs);
            end
         end
      end
      for (int b = 0; b < nb; b++) void'(q_data.pop_front());
      @(negedge clk);
      checks++;
      if (bus.computation_done !== 1'b0 || bus.compute_enable !== 1'b0) begin
         errors++;
         $display("FAIL idle_after got done=%b en=%b want 0/0",
                  bus.computation_done, bus.compute_enable);
      end
   endtask

   task automatic test_reset();
      bus.blk_ready  = 1'b0;
      bus.wrreq_data = 1'b0;
      bus.wrreq_meta = 1'b0;
      bus.fifo_w_data = 8'h0;
      bus.fifo_w_meta = 8'h0;
      reset = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.cOut !== 7'h0 || bus.dOut !== 3'h0 || bus.blk_data !== 8'h0 ||
          bus.blk_meta !== 8'h0 || bus.counter_out !== 13'h0 ||
          bus.compute_enable !== 1'b0 || bus.computation_done !== 1'b0 ||
          bus.instantiate_computation !== 1'b0 ||
          bus.out_to_fifo0 !== 8'h0 || bus.out_to_fifo1 !== 8'h0 ||
          bus.out_to_fifo2 !== 8'h0) begin
         errors++;
         $display("FAIL reset_outputs got c=%h d=%h bd=%h bm=%h cnt=%0d want all 0",
                  bus.cOut, bus.dOut, bus.blk_data, bus.blk_meta, bus.counter_out);
      end
      bus.blk_ready = 1'b1;
      begin
         bit seen;
         seen = 1'b0;
         repeat (6) begin
            @(negedge clk);
            if (bus.instantiate_computation) seen = 1'b1;
         end
         checks++;
         if (seen) begin
            errors++;
            $display("FAIL empty_start got instantiate=1 want 0");
         end
      end
      bus.blk_ready = 1'b0;
   endtask

   task automatic test_tail_biting();
      do_reset();
      wr_data(8'hF3);
      wr_data(8'h05);
      wr_data(8'h19);
      wr_data(8'hC7);
      wr_meta(8'h1E);
      run_block(-1);
      checks++;
      if (first_c !== 7'h78 || first_d !== 3'b101) begin
         errors++;
         $display("FAIL first_window got c=%h d=%b want 78/101", first_c, first_d);
      end
      checks++;
      if (fin_s !== 6'b111000) begin
         errors++;
         $display("FAIL tail_state got %b want 111000", fin_s);
      end
   endtask

   task automatic test_gating();
      bit seen;
      do_reset();
      wr_meta(8'h00);
      wr_data(8'h3C);
      wr_data(8'hA5);
      wr_data(8'h81);
      bus.blk_ready = 1'b1;
      seen = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (bus.instantiate_computation) seen = 1'b1;
      end
      bus.blk_ready = 1'b0;
      checks++;
      if (seen) begin
         errors++;
         $display("FAIL gating_3bytes got instantiate=1 want 0");
      end
      wr_data(8'h7E);
      run_block(-1);
   endtask

   task automatic test_back_to_back();
      do_reset();
      for (int b = 0; b < 4; b++) wr_data(8'($urandom));
      wr_meta(8'h40);
      wr_meta(8'h22);
      for (int b = 0; b < 4; b++) pend.push_back(8'($urandom));
      run_block(-1);
      run_block(-1);
   endtask

   task automatic test_full();
      do_reset();
      for (int b = 0; b < DD + 4; b++) wr_data(8'($urandom));
      wr_meta(8'h01);
      run_block(-1);
   endtask

   task automatic test_random();
      for (int n = 0; n < 8; n++) begin
         logic [7:0] m;
         int need;
         m = 8'($urandom);
         need = (m[0] ? KL : KS) / 8 - q_data.size();
         for (int b = 0; b < need; b++) wr_data(8'($urandom));
         wr_meta(m);
         repeat ($urandom_range(0, 6)) pend.push_back(8'($urandom));
         run_block(-1);
      end
   endtask

   task automatic test_abort();
      bit seen;
      do_reset();
      for (int b = 0; b < 4; b++) wr_data(8'($urandom));
      wr_meta(8'h10);
      run_block(20);
      wr_meta(8'h00);
      bus.blk_ready = 1'b1;
      seen = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (bus.instantiate_computation) seen = 1'b1;
      end
      bus.blk_ready = 1'b0;
      checks++;
      if (seen) begin
         errors++;
         $display("FAIL abort_flush got instantiate=1 want 0");
      end
      for (int b = 0; b < 4; b++) wr_data(8'($urandom));
      run_block(-1);
   endtask

   initial begin
      test_reset();
      test_tail_biting();
      test_gating();
      test_back_to_back();
      test_full();
      test_random();
      test_abort();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
